// File: rtl/cond_flag_if.sv
// Execute-stage flag/condition bundle between the issuing pipeline
// and cond_flag_unit. master drives the instruction, slave consumes it.
interface cond_flag_if;
    logic       valid_in;
    logic [3:0] cond;
    logic [1:0] flag_write;
    logic [3:0] alu_flags;
    logic       reg_w_in;
    logic       mem_w_in;
    logic       pcs_in;
    logic       stall;
    logic       flush;
    logic       cond_ex;
    logic [3:0] flags_q;
    logic       valid_out;
    logic       reg_write;
    logic       mem_write;
    logic       pcsrc;

    modport master (
        output valid_in, cond, flag_write, alu_flags,
        output reg_w_in, mem_w_in, pcs_in, stall, flush,
        input  cond_ex, flags_q, valid_out,
        input  reg_write, mem_write, pcsrc
    );

    modport slave (
        input  valid_in, cond, flag_write, alu_flags,
        input  reg_w_in, mem_w_in, pcs_in, stall, flush,
        output cond_ex, flags_q, valid_out,
        output reg_write, mem_write, pcsrc
    );
endinterface

// File: rtl/cond_flag_unit.sv
// NZCV register, ARMv4 condition check and EX/MEM gated-enable stage.
// Define COND_MISS_CNT_EN to add the cond_miss_cnt squash counter.
module cond_flag_unit #(
    parameter logic [3:0] FLAG_RST = 4'b0000
`ifdef COND_MISS_CNT_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    cond_flag_if.slave        bus
`ifdef COND_MISS_CNT_EN
    ,
    output logic [CNT_W-1:0]  cond_miss_cnt
`endif
);

    logic [3:0] flags_r;
    logic       valid_r;
    logic       rw_r;
    logic       mw_r;
    logic       pcs_r;
    logic       pass;
    logic       go;
    logic       n, z, c, v;

    assign {n, z, c, v} = flags_r;

    // Condition field against the held flags (never the live ALU flags)
    always_comb begin
        pass = 1'b1;
        unique case (bus.cond)
            4'h0:    pass = z;
            4'h1:    pass = !z;
            4'h2:    pass = c;
            4'h3:    pass = !c;
            4'h4:    pass = n;
            4'h5:    pass = !n;
            4'h6:    pass = v;
            4'h7:    pass = !v;
            4'h8:    pass = c & !z;
            4'h9:    pass = !c | z;
            4'hA:    pass = (n == v);
            4'hB:    pass = (n != v);
            4'hC:    pass = !z & (n == v);
            4'hD:    pass = z | (n != v);
            default: pass = 1'b1;
        endcase
    end

    assign go = bus.valid_in & pass & !bus.flush;

    // NZCV register: per-pair load only for an executing, non-stalled op
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_r <= FLAG_RST;
        end else if (!bus.stall && go) begin
            if (bus.flag_write[1]) flags_r[3:2] <= bus.alu_flags[3:2];
            if (bus.flag_write[0]) flags_r[1:0] <= bus.alu_flags[1:0];
        end
    end

    // EX/MEM stage: flush wins over stall and clears the stage
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            valid_r <= 1'b0;
            rw_r    <= 1'b0;
            mw_r    <= 1'b0;
            pcs_r   <= 1'b0;
        end else if (!bus.stall) begin
            valid_r <= go;
            rw_r    <= go & bus.reg_w_in;
            mw_r    <= go & bus.mem_w_in;
            pcs_r   <= go & bus.pcs_in;
        end
    end

`ifdef COND_MISS_CNT_EN
    // Count real instructions squashed by their condition; wraps freely
    always_ff @(posedge clk) begin
        if (rst) begin
            cond_miss_cnt <= '0;
        end else if (!bus.stall && bus.valid_in && !bus.flush && !pass) begin
            cond_miss_cnt <= cond_miss_cnt + 1'b1;
        end
    end
`endif

    assign bus.cond_ex   = pass;
    assign bus.flags_q   = flags_r;
    assign bus.valid_out = valid_r;
    assign bus.reg_write = rw_r;
    assign bus.mem_write = mw_r;
    assign bus.pcsrc     = pcs_r;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Scoreboard bench for cond_flag_unit: a reference model predicts each
// edge, predictions are queued at drive time and popped after the edge.
module tb_cond_flag_unit;

    localparam logic [3:0] FLAG_RST = 4'b0000;

    typedef struct {
        logic [3:0]  flags;
        logic        v;
        logic        rw;
        logic        mw;
        logic        pc;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    cond_flag_if bus ();
`ifdef COND_MISS_CNT_EN
    logic [15:0] cond_miss_cnt;
`endif

    cond_flag_unit #(
        .FLAG_RST (FLAG_RST)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus)
`ifdef COND_MISS_CNT_EN
        ,
        .cond_miss_cnt (cond_miss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t cur;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Reference condition: base test per pair, odd codes invert
    function automatic logic ref_cond(input logic [3:0] cd,
                                      input logic [3:0] f);
        logic b;
        logic nn, zz, cc, vv;
        {nn, zz, cc, vv} = f;
        case (cd[3:1])
            3'd0: b = zz;
            3'd1: b = cc;
            3'd2: b = nn;
            3'd3: b = vv;
            3'd4: b = cc & ~zz;
            3'd5: b = ~(nn ^ vv);
            3'd6: b = ~zz & ~(nn ^ vv);
            default: return 1'b1;
        endcase
        return b ^ cd[0];
    endfunction

    task automatic cycle(input logic r, input logic st, input logic fl,
                         input logic vin, input logic [3:0] cd,
                         input logic [1:0] fw, input logic [3:0] alu,
                         input logic rw, input logic mw, input logic pc);
        exp_t e;
        logic pass, go;
        rst            = r;
        bus.stall      = st;
        bus.flush      = fl;
        bus.valid_in   = vin;
        bus.cond       = cd;
        bus.flag_write = fw;
        bus.alu_flags  = alu;
        bus.reg_w_in   = rw;
        bus.mem_w_in   = mw;
        bus.pcs_in     = pc;
        #1;
        pass = ref_cond(cd, cur.flags);
        if (!$isunknown(cur.flags)) chk("cond_ex", bus.cond_ex, pass);
        go = vin & pass & ~fl;
        e = cur;
        if (r) begin
            e.flags = FLAG_RST;
            e.v = 0; e.rw = 0; e.mw = 0; e.pc = 0;
            e.cnt = 0;
        end else begin
            if (fl) begin
                e.v = 0; e.rw = 0; e.mw = 0; e.pc = 0;
            end else if (!st) begin
                e.v = go; e.rw = go & rw; e.mw = go & mw; e.pc = go & pc;
            end
            if (!st && go) begin
                if (fw[1]) e.flags[3:2] = alu[3:2];
                if (fw[0]) e.flags[1:0] = alu[1:0];
            end
            if (!st && vin && !fl && !pass) e.cnt = e.cnt + 16'd1;
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("flags_q", bus.flags_q, e.flags);
        chk("valid_out", bus.valid_out, e.v);
        chk("reg_write", bus.reg_write, e.rw);
        chk("mem_write", bus.mem_write, e.mw);
        chk("pcsrc", bus.pcsrc, e.pc);
`ifdef COND_MISS_CNT_EN
        chk("cond_miss_cnt", cond_miss_cnt, e.cnt);
`endif
        cur = e;
    endtask

    // Set flags to f with an unconditional full-width write
    task automatic setf(input logic [3:0] f);
        cycle(0, 0, 0, 1, 4'hE, 2'b11, f, 0, 0, 0);
    endtask

    initial begin
        cur.flags = 'x;
        cur.v = 'x; cur.rw = 'x; cur.mw = 'x; cur.pc = 'x;
        cur.cnt = 'x;
        @(negedge clk);
        // reset has priority over stall and flush
        cycle(1, 1, 1, 1, 4'hE, 2'b11, 4'hF, 1, 1, 1);
        chk("reset_flags", bus.flags_q, FLAG_RST);
        // flag set then EQ / NE
        setf(4'b0100);
        chk("z_set", bus.flags_q, 4'b0100);
        cycle(0, 0, 0, 1, 4'h0, 2'b00, 4'h0, 1, 0, 0);
        chk("eq_rw", bus.reg_write, 1'b1);
        cycle(0, 0, 0, 1, 4'h1, 2'b00, 4'h0, 1, 1, 1);
        chk("ne_squash", bus.valid_out, 1'b0);
        // partial update of C,V only
        setf(4'b1010);
        cycle(0, 0, 0, 1, 4'hE, 2'b01, 4'b0101, 0, 0, 0);
        chk("partial", bus.flags_q, 4'b1001);
        // flag write blocked on a failed condition
        cycle(0, 0, 0, 1, 4'h0, 2'b11, 4'b0100, 0, 0, 0);
        // signed conditions
        setf(4'b1000);
        cycle(0, 0, 0, 1, 4'hA, 2'b00, 4'h0, 1, 0, 0);
        cycle(0, 0, 0, 1, 4'hB, 2'b00, 4'h0, 1, 0, 1);
        setf(4'b1001);
        cycle(0, 0, 0, 1, 4'hC, 2'b00, 4'h0, 0, 1, 0);
        cycle(0, 0, 0, 1, 4'hD, 2'b00, 4'h0, 0, 1, 0);
        setf(4'b0100);
        cycle(0, 0, 0, 1, 4'hC, 2'b00, 4'h0, 1, 1, 1);
        cycle(0, 0, 0, 1, 4'hD, 2'b00, 4'h0, 1, 1, 1);
        // back-to-back: second op sees flags from the first
        cycle(0, 0, 0, 1, 4'hE, 2'b11, 4'b0010, 0, 0, 0);
        cycle(0, 0, 0, 1, 4'h2, 2'b00, 4'h0, 0, 0, 1);
        // stall holds everything, then stall+flush clears
        for (int i = 0; i < 3; i++)
            cycle(0, 1, 0, 1, 4'hE, 2'b11, 4'hF, 1, 1, 1);
        cycle(0, 1, 1, 1, 4'hE, 2'b11, 4'hF, 1, 1, 1);
        chk("flush_valid", bus.valid_out, 1'b0);
        // valid_in low ignores flag_write
        cycle(0, 0, 0, 0, 4'hE, 2'b11, 4'hF, 1, 1, 1);
        // random mix
        for (int i = 0; i < 300; i++)
            cycle(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 5) == 0), 1'($urandom),
                  4'($urandom), 2'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
`ifdef COND_MISS_CNT_EN
        // counter wrap
        cycle(1, 0, 0, 0, 4'h0, 2'b00, 4'h0, 0, 0, 0);
        setf(4'b0100);
        for (int i = 0; i < 65535; i++)
            cycle(0, 0, 0, 1, 4'h1, 2'b00, 4'h0, 1, 0, 0);
        chk("cnt_max", cond_miss_cnt, 16'hFFFF);
        cycle(0, 0, 0, 1, 4'h1, 2'b00, 4'h0, 1, 0, 0);
        chk("cnt_wrap", cond_miss_cnt, 16'h0000);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer end of the ALU flag interface: holds the architectural NZCV register fed by the ALU's 4-bit flag output.
- Evaluates the ARMv4 4-bit condition field of the executing instruction against the held flags.
- Gates the instruction's register-write, memory-write and PC-source requests.
- Presents the gated requests one cycle later as a registered execute/memory pipeline stage with stall and flush.

Parameters:
FLAG_RST, 4'b0000, reset value of flags_q, ordered {N,Z,C,V}
CNT_W, 16, width of the squash counter (used only with the optional feature)

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
valid_in  input  1  execute stage holds a real instruction this cycle
cond  input  4  instruction condition field, bits [31:28]
flag_write  input  2  bit1: update N,Z; bit0: update C,V (S-bit decode)
alu_flags  input  4  ALU flags {N,Z,C,V}, same order as the ALU flag output
reg_w_in  input  1  decoded register-write request
mem_w_in  input  1  decoded memory-write request
pcs_in  input  1  decoded PC-source (branch / PC write) request
stall  input  1  hold stage: no register or flag update
flush  input  1  kill the instruction currently in execute
cond_ex  output  1  combinational: condition passed for the current inputs (valid_in not applied)
flags_q  output  4  architectural NZCV register
valid_out  output  1  registered: stage holds an executed (condition-passed) instruction
reg_write  output  1  registered gated register-write
mem_write  output  1  registered gated memory-write
pcsrc  output  1  registered gated PC-source
cond_miss_cnt  output  CNT_W  squash counter (present only with the optional feature)

Behaviour:
- Reset: when rst=1 at a clock edge:
  - flags_q becomes FLAG_RST.
  - valid_out, reg_write, mem_write and pcsrc become 0.
  - cond_miss_cnt becomes 0.
  - rst has priority over stall and flush.
  - Reset mid-operation discards the in-flight instruction; no flag update.
- Condition evaluation uses flags_q, never alu_flags:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - A GE: N==V
  - B LT: N!=V
  - C GT: !Z&(N==V)
  - D LE: Z|(N!=V)
  - E AL: 1
  - F: 1 (unconditional space)
- Define go = valid_in & cond_ex & !flush.
- Flag update at an edge with !rst & !stall & go:
  - flag_write[1] loads N,Z from alu_flags[3:2].
  - flag_write[0] loads C,V from alu_flags[1:0].
  - Unselected bits hold.
  - A failed condition, flush, or stall blocks the update.
- Pipeline register at an edge with !rst & !stall:
  - valid_out <= go
  - reg_write <= go & reg_w_in
  - mem_write <= go & mem_w_in
  - pcsrc <= go & pcs_in
- Stall: all registers hold, including flags_q. stall and flush together behave as flush, which clears the stage: valid_out and all gated enables 0 next cycle, no flag update.
- Latency:
  - Gated enables appear 1 cycle after the instruction is in execute.
  - The flag result is visible on flags_q 1 cycle later.
  - Back-to-back: an instruction's condition sees flags written by the immediately preceding non-stalled instruction.
- Squashed instruction (valid_in=1, cond_ex=0, no flush): stage advances as a bubble (valid_out=0).
- valid_in=0: stage advances as a bubble; flag_write is ignored.

Optional Feature:
- Macro: COND_MISS_CNT_EN.
- Defined:
  - Port cond_miss_cnt exists.
  - Increments by 1 at each edge with !rst & !stall & valid_in & !flush & !cond_ex.
  - Wraps from all-ones to 0.
  - Held during stall.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst=1 with stall=1 and flush=1 → flags_q=FLAG_RST, valid_out=reg_write=mem_write=pcsrc=0, cond_miss_cnt=0.
- Flag set then conditional execution:
  - Cycle 0: cond=E, flag_write=11, alu_flags=0100 (Z=1). Next edge: flags_q=0100.
  - Cycle 1: cond=0 (EQ), reg_w_in=1. Next edge: reg_write=1, valid_out=1.
  - Repeat with cond=1 (NE): reg_write=0, valid_out=0, counter +1.
- Partial update: flags_q=1010, cond=E, flag_write=01, alu_flags=0101 → flags_q=1001.
- Signed conditions:
  - flags_q=1000 (N=1,V=0): cond=A (GE) squashed, cond=B (LT) passes.
  - flags_q=1001: GT passes, LE fails.
  - flags_q=0100: GT fails, LE passes.
- Stall/flush:
  - stall=1 for 3 cycles with cond=E, flag_write=11, alu_flags=1111 → flags_q and outputs unchanged.
  - Then stall=1, flush=1 → valid_out=0, flags_q unchanged.
- Counter wrap (COND_MISS_CNT_EN, CNT_W=16): preload via 65535 squashed instructions (cond=1, flags_q Z=1), one more → cond_miss_cnt=0.
